muldiv_ctrl: RTL and testbench

Multi-cycle multiply/divide controller for the MIPS pipeline, with its HI/LO register pair. It accepts one mult/div/mthi/mtlo operation per issue from the E stage and models the arithmetic latency with a down-counter. It drives the `stall` input of the hazard logic so that any HI/LO-dependent instruction in D is held until the result is committed.

---
 rtl/muldiv_ctrl_pkg.sv | 28 ++
 rtl/muldiv_ctrl_md_alu.sv | 57 +++++
 rtl/muldiv_ctrl.sv | 95 +++++++++
 tb/tb_muldiv_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// rtl/muldiv_ctrl_pkg.sv - shared op codes, FSM states and decode helpers for the MD unit
package muldiv_ctrl_pkg;

  // MD operation codes as issued from the E stage; codes 6 and 7 are unused
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Multi-cycle arithmetic ops occupy the codes with the top bit clear
  function automatic logic is_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_md_alu.sv
// rtl/muldiv_ctrl_md_alu.sv - combinational multiply/divide datapath producing next HI/LO
module md_alu
  import muldiv_ctrl_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n
);

  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] dvd;
  logic        [31:0] dvs;
  logic        [31:0] dvs_safe;
  logic        [31:0] quo;
  logic        [31:0] rem;
  logic               is_sdiv;

  // Products and a magnitude divider; signed DIV fixes signs up afterwards
  always_comb begin
    sa      = {{32{a[31]}}, a};
    sb      = {{32{b[31]}}, b};
    prod_s  = sa * sb;
    prod_u  = {32'd0, a} * {32'd0, b};
    is_sdiv = (op == MD_DIV);
    dvd     = (is_sdiv && a[31]) ? (~a + 32'd1) : a;
    dvs     = (is_sdiv && b[31]) ? (~b + 32'd1) : b;
    // A zero divisor never commits; substitute 1 so the divider stays defined
    dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    quo     = dvd / dvs_safe;
    rem     = dvd % dvs_safe;
    hi_n    = 32'd0;
    lo_n    = 32'd0;
    case (op)
      MD_MULT:  {hi_n, lo_n} = prod_s;
      MD_MULTU: {hi_n, lo_n} = prod_u;
      MD_DIV: begin
        // Quotient truncates toward zero; remainder takes the dividend's sign
        lo_n = (a[31] ^ b[31]) ? (~quo + 32'd1) : quo;
        hi_n = a[31] ? (~rem + 32'd1) : rem;
      end
      MD_DIVU: begin
        lo_n = quo;
        hi_n = rem;
      end
      default: begin
        hi_n = 32'd0;
        lo_n = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multi-cycle MD controller with HI/LO registers and pipeline stall
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

  md_state_e   state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] hi_d;
  logic [31:0] lo_d;

  md_alu u_alu (
    .a    (a_q),
    .b    (b_q),
    .op   (op_q),
    .hi_n (hi_d),
    .lo_n (lo_d)
  );

  // FSM: accept ops in IDLE, count down in BUSY, commit HI/LO on the last busy edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start) begin
            case (md_op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                op_q    <= md_op;
                a_q     <= A;
                b_q     <= B;
                cnt_q   <= is_div(md_op) ? DIV_LOAD : MULT_LOAD;
                state_q <= MD_BUSY;
              end
              MD_MTHI: hi_q <= A;
              MD_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        MD_BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= MD_IDLE;
            // Divide by zero burns the full latency but leaves HI/LO intact
            if (!(is_div(op_q) && (b_q == 32'd0))) begin
              hi_q <= hi_d;
              lo_q <= lo_d;
            end
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  // Hold D while an op is in flight or one is being issued from E this cycle
  always_comb begin
    busy  = (state_q == MD_BUSY);
    stall = md_use_d & (busy | (start & is_arith(md_op)));
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - directed self-checking bench for muldiv_ctrl
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_use_d;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .A        (A),
    .B        (B),
    .md_use_d (md_use_d),
    .busy     (busy),
    .stall    (stall),
    .HI       (HI),
    .LO       (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single edge; returns just after the start edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    step();
    start = 1'b0;
    A     = 32'd0;
    B     = 32'd0;
  endtask

  // Count busy cycles until busy drops, bounded
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset    = 1'b0;
    start    = 1'b0;
    md_op    = 3'd0;
    A        = 32'd0;
    B        = 32'd0;
    md_use_d = 1'b0;
    repeat (3) step();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b1;
    step();

    // MULT -1 * 2
    issue(MD_MULT, 32'hFFFF_FFFF, 32'd2);
    check("mult_busy_start", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFE);

    // MULTU 0xFFFFFFFF * 2, issued the cycle busy fell
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", HI, 32'h0000_0001);
    check("multu_lo", LO, 32'hFFFF_FFFE);

    // DIV -7 / 2
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_cycles", n, 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // DIV 7 / -2: quotient -3, remainder +1
    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_idle(n);
    check("div_neg_lo", LO, 32'hFFFF_FFFD);
    check("div_neg_hi", HI, 32'd1);

    // DIVU 100 / 7, with an MTHI attempt during busy that must be ignored
    issue(MD_DIVU, 32'd100, 32'd7);
    issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
    wait_idle(n);
    check("divu_cycles", n, 32'd9);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    // Consecutive MTHI/MTLO with md_use_d high: no stall, both land
    md_use_d = 1'b1;
    start = 1'b1; md_op = MD_MTHI; A = 32'h0000_1234; #1;
    check("mthi_stall", {31'd0, stall}, 32'd0);
    step();
    md_op = MD_MTLO; A = 32'h0000_5678; #1;
    check("mtlo_stall", {31'd0, stall}, 32'd0);
    check("mthi_hi", HI, 32'h0000_1234);
    step();
    start = 1'b0;
    check("mtlo_lo", LO, 32'h0000_5678);
    check("mt_busy", {31'd0, busy}, 32'd0);
    md_use_d = 1'b0;

    // DIVU by zero leaves HI/LO alone but still takes 10 cycles
    issue(MD_DIVU, 32'd7, 32'd0);
    wait_idle(n);
    check("div0_cycles", n, 32'd10);
    check("div0_hi", HI, 32'h0000_1234);
    check("div0_lo", LO, 32'h0000_5678);

    // Stall window around a MULT with md_use_d held high
    md_use_d = 1'b1;
    #1;
    check("idle_use_stall", {31'd0, stall}, 32'd0);
    start = 1'b1; md_op = MD_MULT; A = 32'd3; B = 32'd5; #1;
    check("stall_pre_t0", {31'd0, stall}, 32'd1);
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_t0p%0d", i), {31'd0, stall}, 32'd1);
      step();
    end
    check("stall_t0p5", {31'd0, stall}, 32'd0);
    check("stall_hi", HI, 32'd0);
    check("stall_lo", LO, 32'd15);

    // Asynchronous reset mid-DIV discards the in-flight result
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (3) step();
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    step();
    reset = 1'b1;
    repeat (15) step();
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_hi", HI, 32'd0);
    check("post_rst_lo", LO, 32'd0);
    md_use_d = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
